// File: rtl/demux_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : demux_event_encoder
// Description : Consumer of a 1-to-8 demultiplexer stage. Each cycle it
//               samples the eight demux outputs Y0..Y7 and latches every
//               asserted channel as a pending event. Pending events are
//               served one at a time as a 3-bit channel index over a
//               valid/ready handshake, in round-robin order. Events that are
//               lost because their channel was already pending set a sticky
//               flag and advance a saturating counter.
//
// Parameters  : EDGE_MODE - 1: an event is a rising edge of Yk
//                           0: an event is every cycle that Yk is high
//               OVF_W     - width of the saturating overflow counter (1..16)
//
// Ports       : clk        in   rising-edge clock
//               rst_n      in   asynchronous active-low reset
//               Y0..Y7     in   demux outputs, synchronous to clk
//               clr_i      in   synchronous clear of the overflow status
//               ready_i    in   consumer accepts idx_o
//               valid_o    out  idx_o holds a valid channel index
//               idx_o      out  channel index of the offered event
//               pending_o  out  pending flags, bit k = channel k
//               ovf_o      out  sticky overflow flag
//               ovf_cnt_o  out  saturating count of cycles with a lost event
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux_event_encoder #(
  parameter int EDGE_MODE = 1,
  parameter int OVF_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Y0,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             Y3,
  input  logic             Y4,
  input  logic             Y5,
  input  logic             Y6,
  input  logic             Y7,
  input  logic             clr_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [2:0]       idx_o,
  output logic [7:0]       pending_o,
  output logic             ovf_o,
  output logic [OVF_W-1:0] ovf_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         y_w;
  logic [7:0]         y_q;
  logic [7:0]         ev_w;
  logic               accept_w;
  logic [7:0]         acc_vec_w;
  logic [7:0]         lost_w;
  logic [7:0]         pending_q, pending_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         cand_w;
  logic [2:0]         sel_idx_w;
  logic               sel_found_w;
  logic               ovf_q, ovf_d;
  logic [OVF_W-1:0]   cnt_q, cnt_d;

  assign y_w = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign ev_w = y_w & ~y_q;
    end else begin : g_level
      assign ev_w = y_w;
    end
  endgenerate

  // One-hot of the channel whose offer is accepted this cycle.
  assign accept_w  = (state_q == S_OFFER) & ready_i;
  assign acc_vec_w = accept_w ? (8'b0000_0001 << idx_q) : 8'b0;

  // A new event wins over its own acceptance, so the bit stays set and the
  // channel is offered again; that case is not counted as lost.
  assign lost_w    = ev_w & pending_q & ~acc_vec_w;
  assign pending_d = ev_w | (pending_q & ~acc_vec_w);

  // Round-robin scan starting just after the last granted channel. The
  // eighth candidate wraps back onto last_q itself.
  always_comb begin
    sel_found_w = 1'b0;
    sel_idx_w   = last_q;
    cand_w      = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand_w = last_q + 3'(i);
      if (!sel_found_w && pending_q[cand_w]) begin
        sel_found_w = 1'b1;
        sel_idx_w   = cand_w;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found_w) begin
          idx_d   = sel_idx_w;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (ready_i) begin
          last_d  = idx_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment; several channels lost in the
  // same cycle count once.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (|lost_w) begin
      ovf_d = 1'b1;
      if (cnt_q != {OVF_W{1'b1}}) begin
        cnt_d = cnt_q + OVF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      y_q       <= 8'b0;
      pending_q <= 8'b0;
      idx_q     <= 3'd0;
      last_q    <= 3'd7;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_w;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o   = (state_q == S_OFFER);
  assign idx_o     = idx_q;
  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;
  assign ovf_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_event_encoder
// Description : Self-checking bench for demux_event_encoder. Instance A uses
//               rising-edge events with a 4-bit counter; instance B uses
//               level events with a 2-bit counter. Expected accepted indices
//               of instance A are queued when the stimulus is driven and
//               popped when the DUT completes a handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_event_encoder;

  logic       clk;
  logic       rst_n;

  logic [7:0] y_a;
  logic       clr_a, ready_a, valid_a, ovf_a;
  logic [2:0] idx_a;
  logic [7:0] pend_a;
  logic [3:0] cnt_a;

  logic [7:0] y_b;
  logic       clr_b, ready_b, valid_b, ovf_b;
  logic [2:0] idx_b;
  logic [7:0] pend_b;
  logic [1:0] cnt_b;

  int         total;
  int         bad;
  int         sb_q[$];

  demux_event_encoder #(.EDGE_MODE(1), .OVF_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .Y0(y_a[0]), .Y1(y_a[1]), .Y2(y_a[2]), .Y3(y_a[3]),
    .Y4(y_a[4]), .Y5(y_a[5]), .Y6(y_a[6]), .Y7(y_a[7]),
    .clr_i(clr_a), .ready_i(ready_a), .valid_o(valid_a), .idx_o(idx_a),
    .pending_o(pend_a), .ovf_o(ovf_a), .ovf_cnt_o(cnt_a)
  );

  demux_event_encoder #(.EDGE_MODE(0), .OVF_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .Y0(y_b[0]), .Y1(y_b[1]), .Y2(y_b[2]), .Y3(y_b[3]),
    .Y4(y_b[4]), .Y5(y_b[5]), .Y6(y_b[6]), .Y7(y_b[7]),
    .clr_i(clr_b), .ready_i(ready_b), .valid_o(valid_b), .idx_o(idx_b),
    .pending_o(pend_b), .ovf_o(ovf_b), .ovf_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    y_a = 8'h00; y_b = 8'h00;
    clr_a = 1'b0; clr_b = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Scoreboard: each completed handshake of instance A pops one entry.
  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        chk("sb_idx", int'(idx_a), sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    ready_a = 1'b1; ready_b = 1'b0;
    y_a = 8'h00; y_b = 8'h00; clr_a = 1'b0; clr_b = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_idx", int'(idx_a), 0);
    chk("rst_pend", int'(pend_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    do_reset();

    // Single pulse on Y3.
    y_a = 8'h08; sb_q.push_back(3);
    tick();
    y_a = 8'h00;
    chk("t1_pend", int'(pend_a), 8'h08);
    chk("t1_valid0", int'(valid_a), 0);
    tick();
    chk("t1_valid1", int'(valid_a), 1);
    chk("t1_idx", int'(idx_a), 3);
    tick();
    chk("t1_pend_clr", int'(pend_a), 0);
    chk("t1_valid_clr", int'(valid_a), 0);
    chk("t1_cnt", int'(cnt_a), 0);

    // Round robin from reset: 0,5,7 then 0,6 (scan restarts after 7).
    do_reset();
    y_a = 8'hA1;
    sb_q.push_back(0); sb_q.push_back(5); sb_q.push_back(7);
    tick();
    y_a = 8'h00;
    tick();
    chk("t2_first", int'(idx_a), 0);
    tick(2);
    chk("t2_second_v", int'(valid_a), 1);
    chk("t2_second", int'(idx_a), 5);
    tick(2);
    chk("t2_third", int'(idx_a), 7);
    tick(2);
    y_a = 8'h41; sb_q.push_back(0); sb_q.push_back(6);
    tick();
    y_a = 8'h00;
    tick(6);
    chk("t2_drain", int'(pend_a), 0);
    chk("t2_sb_empty", sb_q.size(), 0);

    // Offer held under back-pressure while Y2 re-pulses twice.
    do_reset();
    ready_a = 1'b0;
    y_a = 8'h04; sb_q.push_back(2);
    tick();
    y_a = 8'h00;
    tick();
    y_a = 8'h04; tick(); y_a = 8'h00; tick();
    y_a = 8'h04; tick(); y_a = 8'h00; tick();
    chk("t3_valid", int'(valid_a), 1);
    chk("t3_idx", int'(idx_a), 2);
    chk("t3_ovf", int'(ovf_a), 1);
    chk("t3_cnt", int'(cnt_a), 2);
    ready_a = 1'b1;
    tick();
    chk("t3_pend", int'(pend_a), 0);
    tick(3);
    chk("t3_sb_empty", sb_q.size(), 0);

    // Event on Y4 coinciding with acceptance of its own offer.
    do_reset();
    y_a = 8'h10; sb_q.push_back(4);
    tick();
    y_a = 8'h00;
    tick();
    chk("t4_offer", int'(idx_a), 4);
    y_a = 8'h10; sb_q.push_back(4);
    tick();
    y_a = 8'h00;
    chk("t4_pend_kept", int'(pend_a), 8'h10);
    chk("t4_cnt", int'(cnt_a), 0);
    chk("t4_ovf", int'(ovf_a), 0);
    tick();
    chk("t4_reoffer_v", int'(valid_a), 1);
    chk("t4_reoffer", int'(idx_a), 4);
    tick(2);
    chk("t4_pend_clr", int'(pend_a), 0);
    chk("t4_sb_empty", sb_q.size(), 0);

    // Level mode, 2-bit counter: Y1 held high with no consumer.
    do_reset();
    y_b = 8'h02;
    tick(4);
    y_b = 8'h00;
    chk("t5_cnt3", int'(cnt_b), 3);
    chk("t5_ovf", int'(ovf_b), 1);
    chk("t5_valid", int'(valid_b), 1);
    chk("t5_idx", int'(idx_b), 1);
    y_b = 8'h02;
    tick(2);
    chk("t5_sat", int'(cnt_b), 3);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0; y_b = 8'h00;
    chk("t5_clr_ovf", int'(ovf_b), 0);
    chk("t5_clr_cnt", int'(cnt_b), 0);
    chk("t5_clr_pend", int'(pend_b), 8'h02);
    chk("t5_pre_rst_v", int'(valid_b), 1);

    // Asynchronous reset in the middle of an offer.
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(valid_b), 0);
    chk("t6_pend", int'(pend_b), 0);
    chk("t6_ovf", int'(ovf_b), 0);
    chk("t6_cnt", int'(cnt_b), 0);
    tick();
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
